// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and source-stage state type, used by the counter
// source and the gray-to-binary stage. Helpers are width-generic via zero-extension.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        STALL = 2'd2
    } gray_src_state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR by doubling shifts: bit k becomes the XOR of all gray bits >= k.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int s = 1; s < GRAY_MAX_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_code_counter_source.sv
// Up/down binary counter presenting a registered Gray-coded stream over a valid/ready
// handshake, with clear, parallel load, wrap/saturate, terminal-count and overrun flags.
module gray_code_counter_source
    import gray_pkg::*;
#(
    parameter int N       = 4,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic            up_dn,
    input  logic            clr,
    input  logic            load,
    input  logic [N-1:0]    load_bin,
    output logic [N-1:0]    gray_value,
    output logic            gray_valid,
    input  logic            gray_ready,
    output logic            tc,
    output logic            sat,
    output logic            overrun,
    output gray_src_state_t state_o
);

    // Handshake: a value transfers on a cycle where gray_valid & gray_ready are both 1.
    // While gray_valid=1 and gray_ready=0, gray_value is held and the count does not advance.

    logic [N-1:0]    bin_q, bin_d;
    logic [N-1:0]    gray_q, gray_d;
    logic            tc_q, tc_d;
    logic            ovr_q, ovr_d;
    gray_src_state_t state_q, state_d;

    logic free;
    logic adv;
    logic at_limit;
    logic step_ok;

    // gray_valid is exactly "not IDLE", so there is no separate valid register.
    assign gray_valid = (state_q != IDLE);
    assign free       = !gray_valid || gray_ready;
    assign adv        = en && free && !clr && !load;
    assign at_limit   = up_dn ? (bin_q == {N{1'b1}}) : (bin_q == '0);
    assign step_ok    = WRAP_EN || !at_limit;
    assign sat        = !WRAP_EN && at_limit;

    always_comb begin
        bin_d   = bin_q;
        tc_d    = 1'b0;
        ovr_d   = ovr_q;
        state_d = state_q;
        if (clr) begin
            bin_d   = '0;
            ovr_d   = 1'b0;
            state_d = IDLE;
        end else if (load) begin
            bin_d   = load_bin;
            state_d = EMIT;
            if (gray_valid && !gray_ready) begin
                ovr_d = 1'b1;
            end
        end else if (adv && step_ok) begin
            bin_d   = up_dn ? bin_q + 1'b1 : bin_q - 1'b1;
            tc_d    = at_limit;
            state_d = EMIT;
        end else begin
            // Covers plain hold and a saturated advance (which never produces a new value).
            unique case (state_q)
                IDLE:        state_d = IDLE;
                EMIT, STALL: state_d = gray_ready ? IDLE : STALL;
                default:     state_d = IDLE;
            endcase
        end
        gray_d = N'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_q   <= '0;
            gray_q  <= '0;
            tc_q    <= 1'b0;
            ovr_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            tc_q    <= tc_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
        end
    end

    assign gray_value = gray_q;
    assign tc         = tc_q;
    assign overrun    = ovr_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_gray_code_counter_source.sv
// Bench for gray_code_counter_source: a wrapping and a saturating instance share stimulus
// and are compared every cycle against an integer-count reference model and scoreboard.
module tb_gray_code_counter_source;

    localparam int N    = 4;
    localparam int MAXV = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en, up_dn, clr, load, gray_ready;
    logic [N-1:0] load_bin;

    logic [N-1:0] gv_w, gv_s;
    logic         gvalid_w, gvalid_s, tc_w, tc_s, sat_w, sat_s, ovr_w, ovr_s;
    gray_pkg::gray_src_state_t st_w, st_s;

    gray_code_counter_source #(.N(N), .WRAP_EN(1'b1)) dut_wrap (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_bin(load_bin), .gray_value(gv_w), .gray_valid(gvalid_w),
        .gray_ready(gray_ready), .tc(tc_w), .sat(sat_w), .overrun(ovr_w), .state_o(st_w)
    );

    gray_code_counter_source #(.N(N), .WRAP_EN(1'b0)) dut_sat (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_bin(load_bin), .gray_value(gv_s), .gray_valid(gvalid_s),
        .gray_ready(gray_ready), .tc(tc_s), .sat(sat_s), .overrun(ovr_s), .state_o(st_s)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = wrapping instance, 1 = saturating instance.
    int m_cnt[2];
    bit m_valid[2];
    bit m_tc[2];
    bit m_ovr[2];
    int m_age[2];   // cycles the current value has been presented (0 = none)
    logic [N-1:0] exp_q0[$];
    logic [N-1:0] exp_q1[$];

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int from_gray(input int g);
        int b = 0;
        for (int k = N - 1; k >= 0; k--) begin
            b = b | (((((b >> (k + 1)) & 1) ^ ((g >> k) & 1))) << k);
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_valid[i] = 0; m_tc[i] = 0; m_ovr[i] = 0; m_age[i] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic sb_replace(input int i, input int v);
        if (i == 0) begin exp_q0.delete(); exp_q0.push_back(N'(v)); end
        else        begin exp_q1.delete(); exp_q1.push_back(N'(v)); end
    endtask

    task automatic sb_drop(input int i);
        if (i == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    task automatic sb_accept(input int i, input logic [N-1:0] dut_gray);
        logic [N-1:0] e;
        int sz;
        sz = (i == 0) ? exp_q0.size() : exp_q1.size();
        check($sformatf("sb_size%0d", i), sz, 1);
        if (sz > 0) begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("sb_bin%0d", i), from_gray(int'(dut_gray)), int'(e));
        end
    endtask

    // Applies one clock edge of the specified behaviour to the model.
    task automatic model_step(input int i, input bit wrap);
        bit lim;
        if (clr) begin
            m_cnt[i] = 0; m_valid[i] = 0; m_tc[i] = 0; m_ovr[i] = 0; m_age[i] = 0;
            sb_drop(i);
        end else if (load) begin
            if (m_valid[i] && !gray_ready) m_ovr[i] = 1;
            m_cnt[i] = int'(load_bin); m_valid[i] = 1; m_tc[i] = 0; m_age[i] = 1;
            sb_replace(i, m_cnt[i]);
        end else if (en && (!m_valid[i] || gray_ready)) begin
            lim = up_dn ? (m_cnt[i] == MAXV) : (m_cnt[i] == 0);
            if (lim && !wrap) begin
                m_valid[i] = 0; m_tc[i] = 0; m_age[i] = 0;
            end else begin
                m_cnt[i] = (m_cnt[i] + (up_dn ? 1 : -1) + MAXV + 1) % (MAXV + 1);
                m_valid[i] = 1; m_tc[i] = lim; m_age[i] = 1;
                sb_replace(i, m_cnt[i]);
            end
        end else begin
            m_tc[i] = 0;
            if (m_valid[i] && !gray_ready) m_age[i]++;
            else begin m_valid[i] = 0; m_age[i] = 0; end
        end
    endtask

    task automatic check_inst(input int i, input logic [N-1:0] gv, input logic vld,
                              input logic t, input logic s, input logic o, input logic [1:0] st);
        int exp_st;
        bit exp_sat;
        exp_st  = (m_age[i] == 0) ? 0 : (m_age[i] == 1) ? 1 : 2;
        exp_sat = (i == 1) && (up_dn ? (m_cnt[i] == MAXV) : (m_cnt[i] == 0));
        check($sformatf("gray%0d", i),  gv,  to_gray(m_cnt[i]));
        check($sformatf("valid%0d", i), vld, m_valid[i]);
        check($sformatf("tc%0d", i),    t,   m_tc[i]);
        check($sformatf("sat%0d", i),   s,   exp_sat);
        check($sformatf("ovr%0d", i),   o,   m_ovr[i]);
        check($sformatf("state%0d", i), st,  exp_st);
        if (m_valid[i] && gray_ready) sb_accept(i, gv);
    endtask

    // Inputs are applied just after a falling edge; checks run 1 time unit later.
    task automatic cycle();
        #1;
        check_inst(0, gv_w, gvalid_w, tc_w, sat_w, ovr_w, st_w);
        check_inst(1, gv_s, gvalid_s, tc_s, sat_s, ovr_s, st_s);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic u, input logic c, input logic l,
                         input logic [N-1:0] lb, input logic r);
        en = e; up_dn = u; clr = c; load = l; load_bin = lb; gray_ready = r;
        cycle();
    endtask

    int tc_pulses;
    logic [N-1:0] frozen;

    initial begin
        rstn = 1'b0;
        en = 0; up_dn = 1; clr = 0; load = 0; load_bin = '0; gray_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_gray", gv_w, 0);
        check("rst_valid", gvalid_w, 0);
        check("rst_state", st_w, 0);
        check("rst_sat_dn", {sat_s, sat_w}, 2'b00);
        rstn = 1'b1;
        @(negedge clk);

        // Count up through a full wrap.
        tc_pulses = 0;
        for (int k = 0; k < 17; k++) begin
            drive(1, 1, 0, 0, '0, 1);
            if (tc_w) tc_pulses++;
            if (k == 15) check("t1_wrap_gray", gv_w, 0);
        end
        check("t1_tc_pulses", tc_pulses, 1);

        // Down-count wrap from zero.
        drive(0, 0, 0, 1, 4'd0, 1);
        drive(1, 0, 0, 0, '0, 1);
        check("t2_gray", gv_w, 4'b1000);
        check("t2_tc", tc_w, 1);
        drive(0, 0, 0, 0, '0, 1);
        check("t2_tc_drop", tc_w, 0);

        // Backpressure.
        drive(1, 1, 0, 0, '0, 0);
        frozen = gv_w;
        for (int k = 0; k < 5; k++) drive(1, 1, 0, 0, '0, 0);
        check("t3_frozen", gv_w, frozen);
        check("t3_stall", st_w, 2);
        drive(1, 1, 0, 0, '0, 1);
        check("t3_resume", gv_w, to_gray(from_gray(int'(frozen)) + 1));

        // Saturation at the top, then turn around.
        drive(0, 1, 0, 1, 4'hF, 1);
        drive(1, 1, 0, 0, '0, 1);
        drive(1, 1, 0, 0, '0, 1);
        #1;
        check("t4_sat", sat_s, 1);
        check("t4_gray", gv_s, 4'b1000);
        check("t4_novalid", gvalid_s, 0);
        drive(1, 0, 0, 0, '0, 1);
        check("t4_dn_gray", gv_s, 4'b1001);
        check("t4_dn_sat", sat_s, 0);

        // Priority and sticky overrun.
        drive(1, 1, 0, 0, '0, 0);
        drive(0, 0, 1, 1, 4'd5, 0);
        check("t5_clr", {gv_w, gvalid_w, ovr_w}, 0);
        drive(1, 1, 0, 0, '0, 0);
        drive(0, 1, 0, 0, '0, 0);
        drive(0, 1, 0, 1, 4'd9, 0);
        check("t5_ovr", ovr_w, 1);
        for (int k = 0; k < 6; k++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, '0,
                  1'($urandom_range(0, 1)));
        check("t5_ovr_held", ovr_w, 1);
        drive(0, 1, 1, 0, '0, 1);
        check("t5_ovr_clr", ovr_w, 0);

        // Asynchronous reset in the middle of a stall.
        drive(1, 1, 0, 0, '0, 0);
        drive(0, 1, 0, 0, '0, 0);
        #2 rstn = 1'b0;
        #1;
        check("t6_valid", gvalid_w, 0);
        check("t6_state", st_w, 0);
        check("t6_gray", gv_w, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) == 0),
                  N'($urandom_range(0, MAXV)), 1'($urandom_range(0, 2) != 0));
        end
        drive(0, 1, 0, 0, '0, 1);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
